// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared types for the iterative multiply/divide sequencer and its ALU.
package alu_muldiv_sequencer_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 5;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    typedef enum logic [1:0] {
        ALU_NOP = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2
    } alu_fn_t;

    // Decoded instruction as seen by the ALU; the sequencer only ever sets alu_fn.
    typedef struct packed {
        alu_fn_t alu_fn;
        logic    use_imm;
        word_t   imm;
    } instruction_t;

    // Divide ops occupy the upper half of the op encoding.
    function automatic logic is_div_op(input muldiv_op_t o);
        return o[1];
    endfunction

endpackage

// File: rtl/alu_muldiv_sequencer_alu.sv
// Shared combinational ALU: ADD, SUB, and NOP (passes operand b through).
module alu_muldiv_sequencer_alu
    import alu_muldiv_sequencer_pkg::*;
(
    input  instruction_t insn,
    input  word_t        a,
    input  word_t        b,
    output word_t        y_c
);

    word_t opb;

    // Operand select and function decode.
    always_comb begin
        opb = insn.use_imm ? insn.imm : b;
        unique case (insn.alu_fn)
            ALU_ADD: y_c = a + opb;
            ALU_SUB: y_c = a - opb;
            default: y_c = opb;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// 32-iteration unsigned MUL/MULHU/DIVU/REMU sequencer around one shared ALU.
module alu_muldiv_sequencer
    import alu_muldiv_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       start_valid,
    output logic       start_ready,
    input  muldiv_op_t op,
    input  word_t      a,
    input  word_t      b,
    output logic       result_valid,
    input  logic       result_ready,
    output word_t      result,
    output logic       busy
);

    md_state_t        state;
    muldiv_op_t       op_q;
    logic [CNT_W-1:0] count;
    word_t            hi_rem;   // hi (multiply) / rem (divide)
    word_t            lo_quo;   // lo (multiply) / quo (divide)
    word_t            opnd;     // m (multiply) / d (divide)

    instruction_t     insn;
    word_t            alu_a;
    word_t            alu_b;
    word_t            alu_y;
    word_t            sh;
    logic             take;
    logic             carry;
    word_t            hi_rem_n;
    word_t            lo_quo_n;
    word_t            fin;

    alu_muldiv_sequencer_alu u_alu (
        .insn (insn),
        .a    (alu_a),
        .b    (alu_b),
        .y_c  (alu_y)
    );

    // Per-iteration ALU control and next working-register values.
    always_comb begin
        insn     = '0;
        alu_a    = '0;
        alu_b    = '0;
        sh       = {hi_rem[XLEN-2:0], lo_quo[XLEN-1]};
        take     = 1'b0;
        carry    = 1'b0;
        hi_rem_n = hi_rem;
        lo_quo_n = lo_quo;
        fin      = '0;

        if (state == ST_BUSY) begin
            if (is_div_op(op_q)) begin
                insn.alu_fn = ALU_SUB;
                alu_a       = sh;
                alu_b       = opnd;
            end else begin
                insn.alu_fn = lo_quo[0] ? ALU_ADD : ALU_NOP;
                alu_a       = hi_rem;
                alu_b       = lo_quo[0] ? opnd : hi_rem;
            end
        end

        if (is_div_op(op_q)) begin
            // Shifted-out msb means sh really exceeds 32 bits, so it always covers d.
            take     = hi_rem[XLEN-1] || (sh >= opnd);
            hi_rem_n = take ? alu_y : sh;
            lo_quo_n = {lo_quo[XLEN-2:0], take};
        end else begin
            carry    = lo_quo[0] && (alu_y < hi_rem);
            hi_rem_n = {carry, alu_y[XLEN-1:1]};
            lo_quo_n = {alu_y[0], lo_quo[XLEN-1:1]};
        end

        unique case (op_q)
            MD_MUL:   fin = lo_quo_n;
            MD_MULHU: fin = hi_rem_n;
            MD_DIVU:  fin = lo_quo_n;
            default:  fin = hi_rem_n;
        endcase
    end

    // Sequencer state, iteration counter, working registers and result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            op_q   <= MD_MUL;
            count  <= '0;
            hi_rem <= '0;
            lo_quo <= '0;
            opnd   <= '0;
            result <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        op_q  <= op;
                        count <= '0;
                        if (is_div_op(op) && (b == '0)) begin
                            state  <= ST_DONE;
                            result <= (op == MD_DIVU) ? '1 : a;
                        end else begin
                            state  <= ST_BUSY;
                            hi_rem <= '0;
                            lo_quo <= a;
                            opnd   <= b;
                        end
                    end
                end
                ST_BUSY: begin
                    hi_rem <= hi_rem_n;
                    lo_quo <= lo_quo_n;
                    count  <= count + CNT_W'(1);
                    if (count == CNT_W'(ITER - 1)) begin
                        state  <= ST_DONE;
                        result <= fin;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decode straight from state.
    assign start_ready  = (state == ST_IDLE);
    assign result_valid = (state == ST_DONE);
    assign busy         = (state == ST_BUSY) || (state == ST_DONE);

endmodule
